// File: rtl/adpcm_chan_sched.sv
// Per-frame channel scheduler: walks the shared ADPCM datapath through every
// channel (load, compute, update) on each frame strobe, and owns per-channel rate/homing flags.
module adpcm_chan_sched #(
  parameter int NUM_CH      = 32,
  parameter int CALC_CYCLES = 16,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_sync,
  input  logic            rate_wr_en,
  input  logic [CH_W-1:0] rate_wr_ch,
  input  logic [1:0]      rate_wr_data,
  input  logic            ch_rst_req,
  input  logic [CH_W-1:0] ch_rst_ch,
  input  logic            overrun_clr,
  output logic            st_rd_en,
  output logic            st_wr_en,
  output logic [CH_W-1:0] dp_ch,
  output logic [1:0]      dp_rate,
  output logic            dp_reset,
  output logic            dp_start,
  output logic            dp_upd,
  output logic            busy,
  output logic            frame_done,
  output logic            overrun
);

  localparam int CNT_W = $clog2(CALC_CYCLES + 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, UPDATE} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch_idx, ch_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        rate_q [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic              wr_ok, req_ok, load_go;

  assign wr_ok   = rate_wr_en && (32'(rate_wr_ch) < NUM_CH);
  assign req_ok  = ch_rst_req && (32'(ch_rst_ch) < NUM_CH);
  assign load_go = (state_nxt == LOAD);
  assign dp_ch   = ch_idx;

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch_idx;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (frame_sync) begin
          state_nxt = LOAD;
          ch_nxt    = '0;
        end
      end
      LOAD: begin
        state_nxt = CALC;
        cnt_nxt   = CNT_INIT;
      end
      CALC: begin
        if (cnt == '0) state_nxt = UPDATE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      UPDATE: begin
        if (ch_idx == LAST_CH) begin
          state_nxt = IDLE;
          ch_nxt    = '0;
        end else begin
          state_nxt = LOAD;
          ch_nxt    = ch_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ch_idx     <= '0;
      cnt        <= '0;
      st_rd_en   <= 1'b0;
      st_wr_en   <= 1'b0;
      dp_rate    <= 2'b00;
      dp_reset   <= 1'b0;
      dp_start   <= 1'b0;
      dp_upd     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      pend       <= '1;
      for (int c = 0; c < NUM_CH; c++) rate_q[c] <= 2'b01;
    end else begin
      state      <= state_nxt;
      ch_idx     <= ch_nxt;
      cnt        <= cnt_nxt;
      // Outputs are registered from the next-state decode so they line up with the state they describe
      st_rd_en   <= load_go;
      dp_start   <= (state == LOAD);
      dp_upd     <= (state_nxt == UPDATE);
      st_wr_en   <= (state_nxt == UPDATE);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state == UPDATE) && (state_nxt == IDLE);
      if (load_go) begin
        dp_rate  <= rate_q[ch_nxt];
        dp_reset <= pend[ch_nxt] | (req_ok && (ch_rst_ch == ch_nxt));
      end
      if (frame_sync && (state != IDLE)) overrun <= 1'b1;
      else if (overrun_clr)              overrun <= 1'b0;
      // A homing request landing on the slot being loaded keeps the flag pending for the next frame too
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok && (rate_wr_ch == CH_W'(c))) rate_q[c] <= rate_wr_data;
        if (req_ok && (ch_rst_ch == CH_W'(c)))     pend[c] <= 1'b1;
        else if (load_go && (ch_nxt == CH_W'(c)))  pend[c] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_chan_sched.sv
// Bench for adpcm_chan_sched: frame-position reference model plus directed and random stimulus,
// and a second full-size instance for frame length.
module tb_adpcm_chan_sched;

  localparam int NCH  = 4;
  localparam int CALC = 3;
  localparam int S    = CALC + 2;
  localparam int FL   = NCH * S;

  logic test_clk = 1'b0;
  always #5 test_clk = ~test_clk;

  logic       reset = 1'b1, frame_sync = 1'b0, rate_wr_en = 1'b0, ch_rst_req = 1'b0, overrun_clr = 1'b0;
  logic [1:0] rate_wr_ch = '0, rate_wr_data = '0, ch_rst_ch = '0;
  logic       st_rd_en, st_wr_en, dp_reset, dp_start, dp_upd, busy, frame_done, overrun;
  logic [1:0] dp_ch, dp_rate;

  adpcm_chan_sched #(.NUM_CH(NCH), .CALC_CYCLES(CALC)) dut (
    .clk(test_clk), .reset(reset), .frame_sync(frame_sync),
    .rate_wr_en(rate_wr_en), .rate_wr_ch(rate_wr_ch), .rate_wr_data(rate_wr_data),
    .ch_rst_req(ch_rst_req), .ch_rst_ch(ch_rst_ch), .overrun_clr(overrun_clr),
    .st_rd_en(st_rd_en), .st_wr_en(st_wr_en), .dp_ch(dp_ch), .dp_rate(dp_rate),
    .dp_reset(dp_reset), .dp_start(dp_start), .dp_upd(dp_upd), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  logic       b_reset = 1'b1, b_fs = 1'b0;
  logic       b_rd, b_wr, b_dreset, b_start, b_upd, b_busy, b_done, b_ov;
  logic [4:0] b_ch;
  logic [1:0] b_rate;
  logic [4:0] b_zero_ch = '0;
  logic [1:0] b_zero_rate = '0;
  logic       b_zero = 1'b0;

  adpcm_chan_sched #(.NUM_CH(32), .CALC_CYCLES(16)) dut_big (
    .clk(test_clk), .reset(b_reset), .frame_sync(b_fs),
    .rate_wr_en(b_zero), .rate_wr_ch(b_zero_ch), .rate_wr_data(b_zero_rate),
    .ch_rst_req(b_zero), .ch_rst_ch(b_zero_ch), .overrun_clr(b_zero),
    .st_rd_en(b_rd), .st_wr_en(b_wr), .dp_ch(b_ch), .dp_rate(b_rate),
    .dp_reset(b_dreset), .dp_start(b_start), .dp_upd(b_upd), .busy(b_busy),
    .frame_done(b_done), .overrun(b_ov)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit big_finished = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the frame is a position counter; slot and phase follow by division.
  bit       m_active, m_done, m_post_rst, m_ov, m_prev_busy;
  int       m_rel, m_k;
  bit [1:0] m_rate [NCH];
  bit       m_pend [NCH];
  bit [1:0] m_slot_rate;
  bit       m_slot_rst;

  initial forever begin
    @(posedge test_clk);
    cyc++;
    m_done     = 1'b0;
    m_post_rst = 1'b0;
    if (reset) begin
      m_active = 1'b0; m_rel = 0; m_ov = 1'b0; m_post_rst = 1'b1;
      m_k = 0; m_slot_rate = 2'b00; m_slot_rst = 1'b0;
      for (int i = 0; i < NCH; i++) begin m_rate[i] = 2'b01; m_pend[i] = 1'b1; end
    end else begin
      m_prev_busy = m_active;
      if (m_active) begin
        m_rel++;
        if (m_rel > FL) begin m_active = 1'b0; m_done = 1'b1; end
      end else if (frame_sync) begin
        m_active = 1'b1; m_rel = 1;
      end
      if (frame_sync && m_prev_busy) m_ov = 1'b1;
      else if (overrun_clr)          m_ov = 1'b0;
      if (m_active && ((m_rel - 1) % S == 0)) begin
        m_k         = (m_rel - 1) / S;
        m_slot_rate = m_rate[m_k];
        m_slot_rst  = m_pend[m_k] | (ch_rst_req && (int'(ch_rst_ch) == m_k));
        m_pend[m_k] = 1'b0;
      end
      if (rate_wr_en) m_rate[rate_wr_ch] = rate_wr_data;
      if (ch_rst_req) m_pend[ch_rst_ch] = 1'b1;
    end
  end

  int c_ph;
  initial forever begin
    @(negedge test_clk);
    if (cyc > 0) begin
      c_ph = (m_rel - 1) % S;
      chk("busy",       32'(busy),       32'(m_active));
      chk("st_rd_en",   32'(st_rd_en),   32'(m_active && c_ph == 0));
      chk("dp_start",   32'(dp_start),   32'(m_active && c_ph == 1));
      chk("dp_upd",     32'(dp_upd),     32'(m_active && c_ph == S - 1));
      chk("st_wr_en",   32'(st_wr_en),   32'(m_active && c_ph == S - 1));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("overrun",    32'(overrun),    32'(m_ov));
      if (m_active || m_post_rst) begin
        chk("dp_ch",    32'(dp_ch),    32'(m_k));
        chk("dp_rate",  32'(dp_rate),  32'(m_slot_rate));
        chk("dp_reset", 32'(dp_reset), 32'(m_slot_rst));
      end
    end
  end

  task automatic tick();
    @(posedge test_clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    @(negedge test_clk);
    while (cyc < target && g < 5000) begin
      @(negedge test_clk);
      g++;
    end
    if (cyc != target) chk("wait_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic start_frame(output int t);
    t = cyc;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  int t;

  initial begin
    repeat (3) tick();
    @(negedge test_clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dp_rate", 32'(dp_rate), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    tick();

    // Frame 1: every channel homes after reset
    @(negedge test_clk);
    start_frame(t);
    wait_cyc(t + 1);  chk("f1_rd0", 32'(st_rd_en), 1); chk("f1_ch0", 32'(dp_ch), 0);
                      chk("f1_rst0", 32'(dp_reset), 1); chk("f1_rate0", 32'(dp_rate), 1);
    wait_cyc(t + 2);  chk("f1_start0", 32'(dp_start), 1);
    wait_cyc(t + 5);  chk("f1_upd0", 32'(dp_upd), 1);
    wait_cyc(t + 6);  chk("f1_rd1", 32'(st_rd_en), 1); chk("f1_ch1", 32'(dp_ch), 1);
    wait_cyc(t + 16); chk("f1_rd3", 32'(st_rd_en), 1); chk("f1_rst3", 32'(dp_reset), 1);
    wait_cyc(t + 20); chk("f1_upd3", 32'(dp_upd), 1); chk("f1_ch3", 32'(dp_ch), 3);
    wait_cyc(t + 21); chk("f1_done", 32'(frame_done), 1); chk("f1_idle", 32'(busy), 0);

    // Frame 2 begins in the frame_done cycle; ch2 rate written during its CALC
    start_frame(t);
    wait_cyc(t + 1);  chk("f2_rd0", 32'(st_rd_en), 1); chk("f2_rst0", 32'(dp_reset), 0);
                      chk("f2_rate0", 32'(dp_rate), 1); chk("f2_ov", 32'(overrun), 0);
    wait_cyc(t + 12);
    rate_wr_en = 1'b1; rate_wr_ch = 2'd2; rate_wr_data = 2'b11;
    tick();
    rate_wr_en = 1'b0;
    wait_cyc(t + 15); chk("f2_rate2", 32'(dp_rate), 1); chk("f2_upd2", 32'(dp_upd), 1);
    wait_cyc(t + 21); chk("f2_done", 32'(frame_done), 1);

    // Frame 3: new rate visible on ch2, frame_sync while busy
    tick(); tick();
    @(negedge test_clk);
    start_frame(t);
    wait_cyc(t + 6);  chk("f3_rate1", 32'(dp_rate), 1);
    wait_cyc(t + 8);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    wait_cyc(t + 9);  chk("f3_ov", 32'(overrun), 1); chk("f3_ch", 32'(dp_ch), 1);
    wait_cyc(t + 11); chk("f3_rate2", 32'(dp_rate), 3);
    wait_cyc(t + 21); chk("f3_done", 32'(frame_done), 1); chk("f3_ov_hold", 32'(overrun), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge test_clk); chk("ov_cleared", 32'(overrun), 0);

    // Homing request while idle
    ch_rst_req = 1'b1; ch_rst_ch = 2'd1;
    tick();
    ch_rst_req = 1'b0;
    tick();
    @(negedge test_clk);
    start_frame(t);
    wait_cyc(t + 1);  chk("h_rst0", 32'(dp_reset), 0);
    wait_cyc(t + 6);  chk("h_rst1", 32'(dp_reset), 1);
    wait_cyc(t + 11); chk("h_rst2", 32'(dp_reset), 0);
    wait_cyc(t + 21);

    // Request coincident with the ch1 load edge: homes this frame and the next
    start_frame(t);
    wait_cyc(t + 5);
    ch_rst_req = 1'b1; ch_rst_ch = 2'd1;
    tick();
    ch_rst_req = 1'b0;
    @(negedge test_clk); chk("hc_rst1a", 32'(dp_reset), 1);
    wait_cyc(t + 21);
    start_frame(t);
    wait_cyc(t + 6);  chk("hc_rst1b", 32'(dp_reset), 1);
    wait_cyc(t + 11); chk("hc_rst2b", 32'(dp_reset), 0);
    wait_cyc(t + 21);

    // Reset during ch2 CALC
    tick();
    @(negedge test_clk);
    start_frame(t);
    wait_cyc(t + 12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge test_clk);
    chk("mr_busy", 32'(busy), 0); chk("mr_wr", 32'(st_wr_en), 0);
    chk("mr_rate", 32'(dp_rate), 0); chk("mr_ch", 32'(dp_ch), 0);
    wait_cyc(t + 15); chk("mr_no_wr", 32'(st_wr_en), 0);
    start_frame(t);
    wait_cyc(t + 11); chk("mr_rate2", 32'(dp_rate), 1); chk("mr_home2", 32'(dp_reset), 1);
    wait_cyc(t + 16); chk("mr_home3", 32'(dp_reset), 1);
    wait_cyc(t + 21);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      frame_sync   = ($urandom_range(0, 11) == 0);
      rate_wr_en   = ($urandom_range(0, 5) == 0);
      rate_wr_ch   = 2'($urandom_range(0, 3));
      rate_wr_data = 2'($urandom_range(0, 3));
      ch_rst_req   = ($urandom_range(0, 7) == 0);
      ch_rst_ch    = 2'($urandom_range(0, 3));
      overrun_clr  = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 149) == 0);
      tick();
    end
    frame_sync = 1'b0; rate_wr_en = 1'b0; ch_rst_req = 1'b0; overrun_clr = 1'b0; reset = 1'b0;
    repeat (30) tick();

    for (int i = 0; i < 3000 && !big_finished; i++) @(posedge test_clk);
    if (!big_finished) chk("big_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Full-size instance: frame length and back-to-back restart
  int bn;
  initial begin
    repeat (2) @(posedge test_clk);
    #1 b_reset = 1'b0;
    @(posedge test_clk);
    #1;
    for (int rep = 0; rep < 2; rep++) begin
      b_fs = 1'b1;
      @(posedge test_clk);
      #1 b_fs = 1'b0;
      for (bn = 1; bn < 1000; bn++) begin
        @(negedge test_clk);
        if (bn == 1) begin
          chk("big_rd0", 32'(b_rd), 1);
          chk("big_ov", 32'(b_ov), 0);
        end
        if (b_done) break;
        @(posedge test_clk);
        #1;
      end
      chk("big_latency", 32'(bn), 577);
    end
    big_finished = 1'b1;
  end

endmodule

// File: doc/adpcm_chan_sched.md
# adpcm_chan_sched

Per-frame channel scheduler for the multi-channel ADPCM codec. On each 8 kHz frame strobe it steps the shared G.726 datapath (quantizer, adaptive speed control, predictor, delay registers) through every channel in order: load state, compute, update. It replaces the free-running delay-block clock with a single-cycle update strobe, and it holds each channel's rate and pending-homing flags.

## Interface
- NUM_CH, 32: number of channels time-multiplexed onto the datapath (≥2)
- CALC_CYCLES, 16: datapath settle cycles per channel (≥1)
- CH_W, $clog2(NUM_CH): channel index width

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- frame_sync  in  1  one-cycle frame start pulse
- rate_wr_en  in  1  write per-channel rate
- rate_wr_ch  in  CH_W  channel to write
- rate_wr_data  in  2  rate code: 11=16, 10=24, 01=32, 00=40 kb/s
- ch_rst_req  in  1  request homing reset of a channel
- ch_rst_ch  in  CH_W  channel for ch_rst_req
- overrun_clr  in  1  clear sticky overrun
- st_rd_en  out  1  read channel state from state memory
- st_wr_en  out  1  write channel state back
- dp_ch  out  CH_W  current channel (state memory address)
- dp_rate  out  2  RATE to datapath for current slot
- dp_reset  out  1  channel homing reset for current slot
- dp_start  out  1  datapath inputs valid (first CALC cycle)
- dp_upd  out  1  delay-register update strobe
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse, frame complete
- overrun  out  1  sticky: frame_sync arrived while busy

## Operation
- FSM states: IDLE, LOAD, CALC, UPDATE.
- IDLE: on frame_sync, go to LOAD with channel index 0.
- LOAD (1 cycle): st_rd_en=1. Latch dp_rate ← rate[k]. Latch slot homing flag ← pend[k]. Clear pend[k] unless ch_rst_req targets k in the same cycle; the set wins.
- CALC (CALC_CYCLES cycles): a down-counter runs. dp_start=1 on the first CALC cycle only.
- UPDATE (1 cycle): dp_upd=1, st_wr_en=1. If k=NUM_CH-1, go to IDLE and pulse frame_done; otherwise increment k and go to LOAD.
- dp_ch, dp_rate and dp_reset are stable from LOAD through UPDATE of each slot. dp_reset equals the latched homing flag.
- Rate writes take effect in the rate register on the next cycle. A write to the channel currently in its slot affects only the next frame.
- Writes and requests with channel index ≥ NUM_CH are ignored.
- ch_rst_req sets pend[ch] at any time, including while idle.
- frame_sync while busy is ignored and sets overrun. overrun_clr clears it; if overrun_clr and a new overrun occur in the same cycle, the set wins.
- On reset (also mid-frame):
  - Next state is IDLE; no st_wr_en is issued for the interrupted slot.
  - All outputs go to 0, including dp_rate=00 and overrun=0.
  - All rate[k] are set to 01.
  - All pend[k] are set to 1, so the first frame after reset homes every channel.

## Timing
- Slot length S = CALC_CYCLES + 2 cycles. Frame length = NUM_CH·S cycles.
- frame_sync sampled high at cycle t (IDLE):
  - Channel k LOAD at t+1+k·S.
  - dp_start at t+2+k·S.
  - UPDATE at t+k·S+S.
  - busy=1 from t+1 through t+NUM_CH·S.
  - frame_done=1 at t+NUM_CH·S+1, while in IDLE.
- frame_sync in the frame_done cycle is accepted without overrun.
- All outputs are registered. Reset values of all outputs are 0.

## Test plan
Unless a scenario says otherwise: NUM_CH=4, CALC_CYCLES=3, S=5.
1. Reset, then frame_sync at t:
   - dp_ch=0,1,2,3 for 5 cycles each, with st_rd_en at t+1, 6, 11, 16 and dp_upd at t+5, 10, 15, 20.
   - dp_reset=1 in all slots; frame_done at t+21.
   - A second frame shows dp_reset=0 and dp_rate=01 in all slots.
2. rate_wr ch2=11 during ch2 CALC: dp_rate=01 for ch2 in this frame, 11 in the next; other channels stay 01.
3. frame_sync at t+8 while busy: ignored, frame timing unchanged, overrun=1 until overrun_clr, then 0.
4. ch_rst_req ch1 while idle: dp_reset=1 only in the ch1 slot of the next frame. A request for ch1 coincident with ch1 LOAD gives dp_reset=1 for ch1 in that frame and the following one.
5. reset asserted during ch2 CALC: next cycle IDLE, busy=0, all outputs 0, no st_wr_en for ch2. The next frame homes all channels.
6. frame_sync on the frame_done cycle: new frame starts LOAD of ch0 next cycle, overrun stays 0. Repeat with NUM_CH=32, CALC_CYCLES=16: frame_done exactly 577 cycles after frame_sync.
